// File: rtl/teclado_pkg.sv
// teclado_pkg
// Shared definitions for the keypad scanner:
//   state_e   - scanner/debounce state machine states
//   KEY_*     - codes for the non-digit keys of the calculator keypad
//   map4x4    - converts a (row, col) position on the 4x4 keypad to its code
package teclado_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'hF;
  localparam logic [3:0] KEY_HASH = 4'hE;
  localparam logic [3:0] KEY_A    = 4'hD;
  localparam logic [3:0] KEY_B    = 4'hC;
  localparam logic [3:0] KEY_C    = 4'hB;
  localparam logic [3:0] KEY_D    = 4'hA;

  // Physical layout, row-major:  1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] map4x4(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = KEY_A;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = KEY_B;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = KEY_C;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 4'h0;
      4'hE:    code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/teclado_fifo.sv
// teclado_fifo
// Small synchronous FIFO buffering accepted key codes.
// Ports:
//   clk_i    - clock
//   rst_i    - asynchronous active-high reset, empties the FIFO
//   push_i   - write data_i (accepted when not full, or when popping the same cycle)
//   data_i   - code to store
//   pop_i    - remove the head entry (ignored when empty)
//   head_o   - entry at the head, zero while empty
//   full_o   - all DEPTH entries occupied
//   empty_o  - no entries
module teclado_fifo
  import teclado_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             doPush;
  logic             doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  // A pop frees a slot in the same edge, so a push while full is still taken.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  assign head_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + PW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: head_o is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/teclado_scan.sv
// teclado_scan
// Matrix keypad scanner: drives one row low at a time, synchronises and
// debounces the column returns, encodes each accepted press and buffers the
// codes in a FIFO read out over a valid/ready handshake.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   col_n      - column returns, active low, asynchronous
//   row_n      - row drives, active low, at most one low
//   key_code   - code at the FIFO head
//   key_valid  - FIFO not empty
//   key_ready  - consumer takes key_code when key_valid is also high
//   key_held   - an accepted key has not yet been confirmed released
//   overflow   - one-cycle pulse when an accepted code is dropped (FIFO full)
module teclado_scan #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAP_EN     = 1,
  parameter int KEY_W      = ($clog2(ROWS * COLS) > 4) ? $clog2(ROWS * COLS) : 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COLS-1:0]  col_n,
  output logic [ROWS-1:0]  row_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_held,
  output logic             overflow
);

  import teclado_pkg::*;

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [7:0] DEB_CNT = 8'(DEBOUNCE);

  logic [COLS-1:0]  colMeta_q;
  logic [COLS-1:0]  colSync_q;
  logic [SW-1:0]    slot_q, slot_d;
  state_e           state_q, state_d;
  logic [RW-1:0]    rowPtr_q, rowPtr_d;
  logic [CW-1:0]    col_q, col_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             push_q, push_d;
  logic [KEY_W-1:0] pushCode_q, pushCode_d;
  logic             overflow_q, overflow_d;

  logic             sampleNow;
  logic             anyLow;
  logic [CW-1:0]    lowCol;
  logic [RW-1:0]    rowNext;
  logic [7:0]       cntInc;
  logic [KEY_W-1:0] keyCode;
  logic [ROWS-1:0]  rowOneHot;

  logic             fifoPop;
  logic             fifoFull;
  logic             fifoEmpty;

  assign sampleNow = (slot_q == SW'(SCAN_DIV - 1));
  assign anyLow    = ~&colSync_q;
  assign rowNext   = (rowPtr_q == RW'(ROWS - 1)) ? '0 : rowPtr_q + RW'(1);
  assign cntInc    = cnt_q + 8'd1;
  assign rowOneHot = ROWS'(1) << rowPtr_q;

  // Gated by rst directly so that row 0 is driven in the very first cycle
  // after reset is released, giving that slot its full length.
  assign row_n = rst ? '1 : ~rowOneHot;

  // Lowest-index low column wins when several keys share the row.
  always_comb begin
    lowCol = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!colSync_q[i]) lowCol = CW'(i);
    end
  end

  generate
    if (MAP_EN != 0) begin : gMap
      always_comb begin
        keyCode      = '0;
        keyCode[3:0] = map4x4(rowPtr_q[1:0], lowCol[1:0]);
      end
    end else begin : gRaw
      always_comb begin
        keyCode = KEY_W'(rowPtr_q) * KEY_W'(COLS) + KEY_W'(lowCol);
      end
    end
  endgenerate

  // Scan/debounce state machine, evaluated once per slot on its last cycle.
  // The row pointer stays put while debouncing or held so the same row keeps
  // being observed. The state literal DEBOUNCE is package-qualified because
  // the parameter of the same name shadows it inside this module.
  always_comb begin
    state_d    = state_q;
    rowPtr_d   = rowPtr_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    held_d     = held_q;
    push_d     = 1'b0;
    pushCode_d = pushCode_q;
    slot_d     = sampleNow ? '0 : slot_q + SW'(1);

    // key_held rises as the code is written, together with key_valid.
    if (push_q) held_d = 1'b1;

    if (sampleNow) begin
      unique case (state_q)
        SCAN: begin
          if (anyLow) begin
            col_d = lowCol;
            if (DEB_CNT <= 8'd1) begin
              push_d     = 1'b1;
              pushCode_d = keyCode;
              cnt_d      = '0;
              state_d    = HELD;
            end else begin
              cnt_d   = 8'd1;
              state_d = teclado_pkg::DEBOUNCE;
            end
          end else begin
            rowPtr_d = rowNext;
          end
        end

        teclado_pkg::DEBOUNCE: begin
          if (anyLow && (lowCol == col_q)) begin
            if (cntInc >= DEB_CNT) begin
              push_d     = 1'b1;
              pushCode_d = keyCode;
              cnt_d      = '0;
              state_d    = HELD;
            end else begin
              cnt_d = cntInc;
            end
          end else begin
            cnt_d    = '0;
            state_d  = SCAN;
            rowPtr_d = rowNext;
          end
        end

        HELD: begin
          if (!anyLow) begin
            if (cntInc >= DEB_CNT) begin
              cnt_d    = '0;
              held_d   = 1'b0;
              state_d  = SCAN;
              rowPtr_d = rowNext;
            end else begin
              cnt_d = cntInc;
            end
          end else begin
            cnt_d = '0;
          end
        end

        default: state_d = SCAN;
      endcase
    end
  end

  assign fifoPop    = key_valid && key_ready;
  assign overflow_d = push_q && fifoFull && !fifoPop;

  // Synchroniser starts at all-high so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colMeta_q  <= '1;
      colSync_q  <= '1;
      slot_q     <= '0;
      state_q    <= SCAN;
      rowPtr_q   <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      held_q     <= 1'b0;
      push_q     <= 1'b0;
      pushCode_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      colMeta_q  <= col_n;
      colSync_q  <= colMeta_q;
      slot_q     <= slot_d;
      state_q    <= state_d;
      rowPtr_q   <= rowPtr_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      push_q     <= push_d;
      pushCode_q <= pushCode_d;
      overflow_q <= overflow_d;
    end
  end

  teclado_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) uFifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_q),
    .data_i  (pushCode_q),
    .pop_i   (fifoPop),
    .head_o  (key_code),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign key_valid = !fifoEmpty;
  assign key_held  = held_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_teclado_scan.sv
// tb_teclado_scan
// Directed bench for teclado_scan with SCAN_DIV=4, DEBOUNCE=3, FIFO_DEPTH=4
// and the calculator map. A keypad model pulls a column low whenever a pressed
// key sits on the currently driven row.
module tb_teclado_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] colN;
  logic [3:0] rowN;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       keyReady;
  logic       keyHeld;
  logic       overflow;

  // Bit r*4+c set means the key at row r, column c is pressed.
  logic [15:0] pressed;

  int errors = 0;
  int checks = 0;
  int cycleCount = 0;
  int ovfCount = 0;
  logic [3:0] got[$];

  typedef struct {
    logic [15:0] pressMask;
    logic [3:0]  expRowN;
    logic        expValid;
  } vec_t;

  vec_t idleVec[17];
  logic [3:0] rowSeq[4];
  logic [3:0] drainExp[4];
  int at;
  int base;
  int ovfBase;

  teclado_scan #(
    .ROWS       (4),
    .COLS       (4),
    .SCAN_DIV   (4),
    .DEBOUNCE   (3),
    .FIFO_DEPTH (4),
    .MAP_EN     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (colN),
    .row_n     (rowN),
    .key_code  (keyCode),
    .key_valid (keyValid),
    .key_ready (keyReady),
    .key_held  (keyHeld),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key connects its row drive to its column return.
  always_comb begin
    colN = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !rowN[r]) colN[c] = 1'b0;
      end
    end
  end

  // Cycle index since reset release, popped codes and overflow pulses.
  always @(posedge clk) begin
    if (rst) cycleCount <= 0;
    else     cycleCount <= cycleCount + 1;
    if (!rst && keyValid && keyReady) got.push_back(keyCode);
    if (overflow) ovfCount <= ovfCount + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input logic ready);
    pressed  = mask;
    keyReady = ready;
  endtask

  // Returns at the negedge where rst falls (cycle 0).
  task automatic resetDut(input logic [15:0] mask);
    @(negedge clk);
    rst = 1'b1;
    pressed = mask;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitUntilCycle(input int n);
    while (cycleCount < n) @(negedge clk);
  endtask

  task automatic waitValid(input int budget, output int seen);
    seen = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (keyValid) begin
        seen = cycleCount;
        break;
      end
    end
  endtask

  task automatic waitHeld(input logic level, input int budget, output int seen);
    seen = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (keyHeld == level) begin
        seen = cycleCount;
        break;
      end
    end
  endtask

  task automatic pressKey(input int r, input int c, input string name);
    int s;
    pressed = 16'(1) << (r * 4 + c);
    waitHeld(1'b1, 200, s);
    checkOutput({name, " accepted"}, int'(s >= 0), 1);
    pressed = '0;
    waitHeld(1'b0, 200, s);
    checkOutput({name, " released"}, int'(s >= 0), 1);
  endtask

  function automatic int gotAt(input int idx);
    if (idx < got.size()) return int'(got[idx]);
    return -1;
  endfunction

  initial begin
    rowSeq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int i = 0; i < 17; i++) begin
      idleVec[i].pressMask = '0;
      idleVec[i].expRowN   = rowSeq[(i / 4) % 4];
      idleVec[i].expValid  = 1'b0;
    end
    drainExp = '{4'h7, 4'h8, 4'h9, 4'hF};

    rst = 1'b1;
    applyStimulus('0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("reset row_n", rowN, 4'hF);
    checkOutput("reset key_valid", keyValid, 0);
    checkOutput("reset key_code", keyCode, 0);
    checkOutput("reset key_held", keyHeld, 0);
    checkOutput("reset overflow", overflow, 0);

    // Idle scan: each row low for 4 cycles, rows 0..3 then back to 0.
    rst = 1'b0;
    #1;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      applyStimulus(idleVec[i].pressMask, 1'b1);
      checkOutput($sformatf("idle row_n cycle %0d", i), rowN, idleVec[i].expRowN);
      checkOutput($sformatf("idle key_valid cycle %0d", i), keyValid, idleVec[i].expValid);
    end

    // Key 0 (row 3, col 1) held from reset: samples at 15,19,23, push at 24.
    base = got.size();
    resetDut(16'(1) << 13);
    waitValid(100, at);
    checkOutput("key0 valid cycle", at, 25);
    checkOutput("key0 code", keyCode, 4'h0);
    checkOutput("key0 held with valid", keyHeld, 1);
    pressed = '0;
    waitHeld(1'b0, 100, at);
    checkOutput("key0 release cycle", at, 36);
    repeat (40) @(negedge clk);
    checkOutput("key0 push count", got.size() - base, 1);
    checkOutput("key0 popped code", gotAt(base), 4'h0);

    // Bounce on key A: one matching sample, one open sample, then stable.
    base = got.size();
    resetDut(16'(1) << 3);
    waitUntilCycle(4);
    pressed = '0;
    waitUntilCycle(8);
    pressed = 16'(1) << 3;
    waitValid(100, at);
    checkOutput("bounce valid cycle", at, 33);
    checkOutput("bounce code", keyCode, 4'hD);
    pressed = '0;
    waitHeld(1'b0, 100, at);
    checkOutput("bounce released", int'(at >= 0), 1);
    repeat (20) @(negedge clk);
    checkOutput("bounce push count", got.size() - base, 1);
    checkOutput("bounce popped code", gotAt(base), 4'hD);

    // Keys 1, 2, 3 together: lowest column wins.
    base = got.size();
    resetDut(16'h0007);
    waitValid(100, at);
    checkOutput("multi valid cycle", at, 13);
    checkOutput("multi code", keyCode, 4'h1);
    pressed = '0;
    waitHeld(1'b0, 100, at);
    checkOutput("multi released", int'(at >= 0), 1);
    repeat (20) @(negedge clk);
    checkOutput("multi push count", got.size() - base, 1);
    checkOutput("multi popped code", gotAt(base), 4'h1);

    // Five keys with key_ready low: the fifth is dropped.
    resetDut('0);
    keyReady = 1'b0;
    ovfBase = ovfCount;
    base = got.size();
    pressKey(2, 0, "key7");
    checkOutput("ovf head after 7", keyCode, 4'h7);
    pressKey(2, 1, "key8");
    checkOutput("ovf head after 8", keyCode, 4'h7);
    pressKey(2, 2, "key9");
    pressKey(3, 0, "keyStar");
    checkOutput("ovf head after star", keyCode, 4'h7);
    checkOutput("ovf pulses before hash", ovfCount - ovfBase, 0);
    pressKey(3, 2, "keyHash");
    checkOutput("ovf pulses after hash", ovfCount - ovfBase, 1);
    checkOutput("ovf valid while full", keyValid, 1);
    checkOutput("ovf head stable", keyCode, 4'h7);
    keyReady = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("drain count", got.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain entry %0d", i), gotAt(base + i), drainExp[i]);
    end
    checkOutput("drain valid low", keyValid, 0);

    // Reset while held with two codes buffered.
    resetDut('0);
    keyReady = 1'b0;
    pressKey(1, 1, "key5");
    pressed = 16'(1) << 6;
    waitHeld(1'b1, 200, at);
    checkOutput("held6 accepted", int'(at >= 0), 1);
    checkOutput("held6 head", keyCode, 4'h5);
    rst = 1'b1;
    #1;
    checkOutput("midreset key_valid", keyValid, 0);
    checkOutput("midreset key_held", keyHeld, 0);
    checkOutput("midreset row_n", rowN, 4'hF);
    checkOutput("midreset key_code", keyCode, 0);
    pressed = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post reset row_n", rowN, 4'b1110);
    repeat (8) @(negedge clk);
    checkOutput("post reset fifo empty", keyValid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
